// File: rtl/bitserial_pkg.sv
// bitserial_pkg: shared defaults, accumulator guard width and FSM encoding
// for the bit-serial MAC array.
package bitserial_pkg;
    localparam int DATA_W_DEF    = 16;
    localparam int WGT_W_DEF     = 8;
    localparam int LANES_DEF     = 4;
    localparam int FRAC_BITS_DEF = 4;
    localparam int GUARD_BITS    = 4;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;
endpackage

// File: rtl/bitserial_lane.sv
// bitserial_lane: one MAC lane -- operand latch, shift-add accumulator and
// the fixed-point rescale/saturate stage feeding the held result.
module bitserial_lane
    import bitserial_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int WGT_W     = WGT_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int IDX_W     = $clog2(WGT_W)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_i,
    input  logic                     clear_i,
    input  logic signed [DATA_W-1:0] neuron_i,
    input  logic                     step_i,
    input  logic                     bit_i,
    input  logic                     last_i,
    input  logic [IDX_W-1:0]         idx_i,
    output logic signed [DATA_W-1:0] result_o,
    output logic                     overflow_o
);
    localparam int ACC_W = DATA_W + WGT_W + GUARD_BITS;
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    logic signed [DATA_W-1:0] neuron_q, result_q, result_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, term, scaled;
    logic                     overflow_q, overflow_d;

    // The weight MSB carries negative significance in two's complement, so it subtracts.
    always_comb begin
        term       = {{(WGT_W+GUARD_BITS){neuron_q[DATA_W-1]}}, neuron_q} << idx_i;
        acc_d      = load_i ? (clear_i ? '0 : acc_q)
                   : (step_i && bit_i) ? (last_i ? acc_q - term : acc_q + term) : acc_q;
        scaled     = acc_d >>> FRAC_BITS;
        overflow_d = (scaled > SAT_HI) || (scaled < SAT_LO);
        result_d   = scaled > SAT_HI ? SAT_HI[DATA_W-1:0]
                   : scaled < SAT_LO ? SAT_LO[DATA_W-1:0] : scaled[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neuron_q   <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (load_i) neuron_q <= neuron_i;
            if (step_i && last_i) begin
                result_q   <= result_d;
                overflow_q <= overflow_d;
            end
        end
    end

    assign result_o   = result_q;
    assign overflow_o = overflow_q;
endmodule

// File: rtl/bitserial_mac_array.sv
// bitserial_mac_array: LANES parallel bit-serial signed MACs sharing one
// IDLE/RUN controller and weight-bit counter.
module bitserial_mac_array
    import bitserial_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int WGT_W     = WGT_W_DEF,
    parameter int LANES     = LANES_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    acc_clear,
    input  logic [LANES*DATA_W-1:0] neuron_in,
    input  logic                    weight_valid,
    input  logic [LANES-1:0]        weight_bits,
    output logic                    busy,
    output logic                    done,
    output logic [LANES*DATA_W-1:0] result,
    output logic [LANES-1:0]        overflow
);
    localparam int IDX_W = $clog2(WGT_W);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             done_q, load, step, last;

    always_comb begin
        load    = start && (state_q == IDLE);
        step    = weight_valid && (state_q == RUN);
        last    = cnt_q == IDX_W'(WGT_W-1);
        state_d = load ? RUN : (step && last) ? IDLE : state_q;
        cnt_d   = load ? '0 : step ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= step && last;
        end
    end

    assign busy = state_q == RUN;
    assign done = done_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        bitserial_lane #(
            .DATA_W(DATA_W), .WGT_W(WGT_W), .FRAC_BITS(FRAC_BITS), .IDX_W(IDX_W)
        ) u_lane (
            .clk(clk),
            .reset(reset),
            .load_i(load),
            .clear_i(acc_clear),
            .neuron_i(neuron_in[k*DATA_W +: DATA_W]),
            .step_i(step),
            .bit_i(weight_bits[k]),
            .last_i(last),
            .idx_i(cnt_q),
            .result_o(result[k*DATA_W +: DATA_W]),
            .overflow_o(overflow[k])
        );
    end
endmodule

// File: tb/tb_bitserial_mac_array.sv
// tb_bitserial_mac_array: directed and random passes against an arithmetic
// reference model; a monitor scores every done pulse from a queue.
module tb_bitserial_mac_array;
    localparam int DW = 16;
    localparam int WW = 8;
    localparam int LN = 4;
    localparam int FB = 4;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, acc_clear = 1'b0, weight_valid = 1'b0;
    logic [LN*DW-1:0] neuron_in = '0;
    logic [LN-1:0]    weight_bits = '0;
    logic             busy, done;
    logic [LN*DW-1:0] result;
    logic [LN-1:0]    overflow;

    typedef struct {
        logic [LN*DW-1:0] res;
        logic [LN-1:0]    ovf;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    exp_t             m_e;
    longint           acc_m[LN];
    int               n_chk = 0, n_pass = 0, cyc = 0;
    logic [LN*DW-1:0] last_res = '0;
    logic [LN*DW-1:0] n29;
    logic [LN*WW-1:0] w29;

    bitserial_mac_array #(.DATA_W(DW), .WGT_W(WW), .LANES(LN), .FRAC_BITS(FB)) dut (
        .clk(clk), .reset(reset), .start(start), .acc_clear(acc_clear),
        .neuron_in(neuron_in), .weight_valid(weight_valid), .weight_bits(weight_bits),
        .busy(busy), .done(done), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: signed multiply, floor-divide by 2^FB, clamp to the lane range.
    task automatic predict(input logic [LN*DW-1:0] n, input logic [LN*WW-1:0] w,
                           input logic clr, output exp_t e);
        longint hi = (longint'(1) << (DW-1)) - 1;
        longint lo = -hi - 1;
        e.res = '0;
        e.ovf = '0;
        e.cyc = 0;
        for (int k = 0; k < LN; k++) begin
            longint nv = longint'($signed(n[k*DW +: DW]));
            longint wv = longint'($signed(w[k*WW +: WW]));
            longint r;
            if (clr) acc_m[k] = 0;
            acc_m[k] += nv * wv;
            r = acc_m[k] >>> FB;
            e.ovf[k] = (r > hi) || (r < lo);
            r = r > hi ? hi : r < lo ? lo : r;
            e.res[k*DW +: DW] = r[DW-1:0];
        end
    endtask

    // Called one delta after a rising edge; returns one delta after the last-bit edge.
    task automatic pass(input logic [LN*DW-1:0] n, input logic [LN*WW-1:0] w,
                        input logic clr, input int stall_at, input int stall_len);
        exp_t e;
        predict(n, w, clr, e);
        start = 1'b1;
        acc_clear = clr;
        neuron_in = n;
        @(posedge clk); #1;
        start = 1'b0;
        acc_clear = 1'b0;
        neuron_in = {$urandom, $urandom};
        for (int i = 0; i < WW; i++) begin
            if (i == stall_at) begin
                weight_valid = 1'b0;
                start = 1'b1;
                acc_clear = 1'b1;
                repeat (stall_len) begin
                    @(posedge clk); #1;
                    chk("busy_stall", 64'(busy), 64'd1);
                end
                chk("hold_stall", result, last_res);
                start = 1'b0;
                acc_clear = 1'b0;
            end
            weight_valid = 1'b1;
            for (int k = 0; k < LN; k++) weight_bits[k] = w[k*WW + i];
            @(posedge clk); #1;
        end
        weight_valid = 1'b0;
        weight_bits = LN'($urandom);
        e.cyc = cyc;
        sb.push_back(e);
        last_res = e.res;
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_done: got done=1 expected no pending pass");
            end else begin
                m_e = sb.pop_front();
                chk("result", result, m_e.res);
                chk("overflow", 64'(overflow), 64'(m_e.ovf));
                chk("done_cycle", 64'(cyc), 64'(m_e.cyc));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [LN*DW-1:0] n;
        logic [LN*WW-1:0] w;
        int since_clr = 0;
        for (int k = 0; k < LN; k++) acc_m[k] = 0;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        n29 = {$urandom, $urandom};
        w29 = {$urandom};
        n29[15:0] = 16'h1960;
        w29[7:0] = 8'h11;
        pass(n29, w29, 1'b1, -1, 0);
        chk("req029_lane0", 64'(result[15:0]), 64'h1AF6);
        chk("req029_ovf0", 64'(overflow[0]), 64'd0);

        n = {$urandom, $urandom}; w = {$urandom};
        n[15:0] = 16'h0100; w[7:0] = 8'hF0;
        pass(n, w, 1'b1, -1, 0);
        chk("req030_lane0", 64'(result[15:0]), 64'hFF00);
        chk("req030_ovf0", 64'(overflow[0]), 64'd0);

        n = {$urandom, $urandom}; w = {$urandom};
        n[15:0] = 16'h7FFF; w[7:0] = 8'h7F;
        pass(n, w, 1'b1, -1, 0);
        chk("req031a_lane0", 64'(result[15:0]), 64'h7FFF);
        chk("req031a_ovf0", 64'(overflow[0]), 64'd1);
        n[15:0] = 16'h8000;
        pass(n, w, 1'b1, -1, 0);
        chk("req031b_lane0", 64'(result[15:0]), 64'h8000);
        chk("req031b_ovf0", 64'(overflow[0]), 64'd1);

        n = {$urandom, $urandom}; w = {$urandom};
        n[15:0] = 16'd100; w[7:0] = 8'h10;
        pass(n, w, 1'b1, -1, 0);
        chk("req032a_lane0", 64'(result[15:0]), 64'h0064);
        pass(n, w, 1'b0, -1, 0);
        chk("req032b_lane0", 64'(result[15:0]), 64'h00C8);

        pass(n29, w29, 1'b1, 4, 3);
        chk("req033_lane0", 64'(result[15:0]), 64'h1AF6);

        // Weight bits presented while idle must not touch the accumulators.
        weight_valid = 1'b1;
        repeat (3) begin weight_bits = LN'($urandom); @(posedge clk); #1; end
        weight_valid = 1'b0;
        pass(n29, w29, 1'b0, -1, 0);

        start = 1'b1; acc_clear = 1'b1; neuron_in = n29;
        @(posedge clk); #1;
        start = 1'b0; acc_clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            weight_valid = 1'b1;
            for (int k = 0; k < LN; k++) weight_bits[k] = w29[k*WW + i];
            if (i < 5) begin @(posedge clk); #1; end
        end
        #2 reset = 1'b1;
        #1;
        chk("req034_busy", 64'(busy), 64'd0);
        chk("req034_result", result, 64'd0);
        chk("req034_overflow", 64'(overflow), 64'd0);
        chk("req034_done", 64'(done), 64'd0);
        weight_valid = 1'b0;
        for (int k = 0; k < LN; k++) acc_m[k] = 0;
        last_res = '0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(posedge clk); #1;
        pass(n29, w29, 1'b1, -1, 0);
        chk("req034_fresh", 64'(result[15:0]), 64'h1AF6);

        for (int p = 0; p < 40; p++) begin
            logic clr;
            for (int k = 0; k < LN; k++) begin
                int sel = int'($urandom_range(0, 3));
                n[k*DW +: DW] = sel == 0 ? 16'h7FFF : sel == 1 ? 16'h8000 : 16'($urandom);
            end
            w = {$urandom};
            clr = ($urandom_range(0, 3) == 0) || (since_clr >= 8);
            since_clr = clr ? 0 : since_clr + 1;
            if ($urandom_range(0, 2) == 0) begin
                weight_valid = 1'b1;
                repeat ($urandom_range(1, 3)) begin
                    weight_bits = LN'($urandom);
                    @(posedge clk); #1;
                end
                weight_valid = 1'b0;
            end
            if ($urandom_range(0, 2) == 0)
                pass(n, w, clr, int'($urandom_range(0, WW-1)), int'($urandom_range(1, 3)));
            else
                pass(n, w, clr, -1, 0);
        end

        repeat (4) @(posedge clk); #1;
        chk("drain", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bitserial_mac_array.md
BITSERIAL_MAC_ARRAY -- requirements
Module: bitserial_mac_array

Interface
REQ-001 Parameter DATA_W, default 16, width of each signed neuron operand and each result lane.
REQ-002 Parameter WGT_W, default 8, width of each signed two's-complement weight, streamed serially LSB first.
REQ-003 Parameter LANES, default 4, number of parallel multiply-accumulate lanes.
REQ-004 Parameter FRAC_BITS, default 4, number of weight fraction bits removed from the accumulator before output.
REQ-005 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port start  input  1  request to begin one product pass; honoured only when busy=0.
REQ-008 Port acc_clear  input  1  sampled with an accepted start: 1 zeroes accumulators first, 0 adds to the prior sum.
REQ-009 Port neuron_in  input  LANES*DATA_W  signed operands, lane k at bits [k*DATA_W +: DATA_W], latched on an accepted start.
REQ-010 Port weight_valid  input  1  weight_bits carries a valid bit this cycle.
REQ-011 Port weight_bits  input  LANES  one weight bit per lane, LSB first.
REQ-012 Port busy  output  1  high while a pass is in progress.
REQ-013 Port done  output  1  single-cycle pulse marking result update.
REQ-014 Port result  output  LANES*DATA_W  saturated signed results, held between done pulses.
REQ-015 Port overflow  output  LANES  per-lane flag: saturation applied to the current result.

Function
REQ-016 FSM states IDLE and RUN; IDLE->RUN on start in IDLE; RUN->IDLE on the cycle the bit-WGT_W-1 weight bit is accepted.
REQ-017 start during RUN is ignored; weight_valid during IDLE is ignored.
REQ-018 Bit counter 0..WGT_W-1 advances only when weight_valid=1 in RUN; weight_valid low stalls with no state change.
REQ-019 Accepted bit i=1 adds sign-extended neuron<<i to the lane accumulator; bit WGT_W-1 =1 subtracts neuron<<(WGT_W-1).
REQ-020 Accumulator width DATA_W+WGT_W+4 signed, so 16 full-scale passes cannot wrap.
REQ-021 Acc_clear=1 on start zeroes the accumulator in the same edge that latches neuron_in.
REQ-022 Cycle after the last bit: result = accumulator arithmetic-shifted right FRAC_BITS (floor), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; done=1; overflow set per lane if clipped, else cleared.
REQ-023 busy=0 in the done cycle; a start in that cycle is accepted (back-to-back passes).
REQ-024 Accumulators keep their value in IDLE; result and overflow change only at done.

Reset
REQ-025 reset clears state to IDLE, bit counter, accumulators, latched operands, result, overflow, done and busy to 0, immediately and regardless of state.
REQ-026 Reset mid-pass discards the pass; no done pulse follows.

Structure
REQ-027 Package bitserial_pkg holds default parameter values, guard-bit constant (4), and the IDLE/RUN state encoding.
REQ-028 Sub-module bitserial_lane (operand latch, accumulator, shift/saturate) instantiated LANES times via generate; FSM and counter shared in the top.

Verification
REQ-029 Lane0 neuron 0x1960, acc_clear=1, weight 0x11 bits 1,0,0,0,1,0,0,0 -> result lane0 0x1AF6, overflow0=0, done exactly one cycle after 8th bit.
REQ-030 Neuron 0x0100, weight 0xF0 (-1.0) -> result 0xFF00, overflow=0.
REQ-031 Neuron 0x7FFF, weight 0x7F -> result 0x7FFF, overflow=1; next pass neuron 0x8000 weight 0x7F -> 0x8000, overflow=1.
REQ-032 Pass1 neuron 100 weight 0x10 acc_clear=1 -> 0x0064; pass2 same, acc_clear=0 -> 0x00C8.
REQ-033 Weight_valid dropped 3 cycles between bits 3 and 4 -> identical result to REQ-029, done delayed 3 cycles; start during RUN ignored.
REQ-034 Reset asserted after bit 4 -> busy=0, result=0, no done; fresh pass afterwards yields REQ-029 values.
